// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared opcode, funct and ALU-op constants plus the ID/EX control bundle.
package id_stage_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ALU_OP_W = 4;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_SLT = 4'd8
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
    logic    branch;
    logic    branch_ne;
    logic    valid;
  } ctrl_t;

endpackage

// File: rtl/register_file_8bit.sv
// register_file_8bit: 32 x XLEN registers, 2 combinational reads, 1 write at posedge.
// x0 always reads 0. Macro ID_REGFILE_BYPASS_EN makes a same-cycle write visible on the read ports.
module register_file_8bit
  import id_stage_pkg::*;
#(
  parameter int unsigned XLEN = 8
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [XLEN-1:0]   o_rdata1,
  output logic [XLEN-1:0]   o_rdata2
);

  logic [XLEN-1:0] r_regs [NUM_REGS];

  // Storage: async clear, x0 is never written so it stays 0
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

`ifdef ID_REGFILE_BYPASS_EN
  logic w_byp1;
  logic w_byp2;
  assign w_byp1   = i_we && (i_waddr != '0) && (i_waddr == i_raddr1);
  assign w_byp2   = i_we && (i_waddr != '0) && (i_waddr == i_raddr2);
  assign o_rdata1 = w_byp1 ? i_wdata : r_regs[i_raddr1];
  assign o_rdata2 = w_byp2 ? i_wdata : r_regs[i_raddr2];
`else
  assign o_rdata1 = r_regs[i_raddr1];
  assign o_rdata2 = r_regs[i_raddr2];
`endif

endmodule

// File: rtl/id_stage.sv
// id_stage: decode stage of the 8-bit RV pipeline (decode, immediates, load-use stall, ID/EX register).
// Optional macro ID_REGFILE_BYPASS_EN enables write-through bypass in the register file.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int unsigned PC_SIZE = 10,
  parameter int unsigned XLEN    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PC_SIZE-1:0] PC_in,
  input  logic [31:0]        instruction_in,
  input  logic               flush,
  input  logic               wb_we,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               ex_mem_read,
  input  logic [REG_AW-1:0]  ex_rd,
  output logic               stall,
  output logic [PC_SIZE-1:0] PC_out,
  output logic [XLEN-1:0]    rs1_data,
  output logic [XLEN-1:0]    rs2_data,
  output logic [XLEN-1:0]    imm,
  output logic [REG_AW-1:0]  rs1,
  output logic [REG_AW-1:0]  rs2,
  output logic [REG_AW-1:0]  rd,
  output logic [3:0]         alu_op,
  output logic               alu_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               branch,
  output logic               branch_ne,
  output logic               valid
);

  logic [6:0]        w_opcode;
  logic [6:0]        w_funct7;
  logic [2:0]        w_funct3;
  logic [REG_AW-1:0] w_rs1_idx;
  logic [REG_AW-1:0] w_rs2_idx;
  logic [REG_AW-1:0] w_rd_idx;
  logic              w_r_type;
  logic              w_alu_ok;
  alu_op_e           w_alu_op;
  ctrl_t             w_ctrl;
  logic [XLEN-1:0]   w_imm;
  logic              w_rs1_used;
  logic              w_rs2_used;
  logic [XLEN-1:0]   w_rf_rd1;
  logic [XLEN-1:0]   w_rf_rd2;
  logic              w_hazard;
  logic              w_bubble;

  ctrl_t             r_ctrl;
  logic [PC_SIZE-1:0] r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;

  assign w_opcode  = instruction_in[6:0];
  assign w_rd_idx  = instruction_in[11:7];
  assign w_funct3  = instruction_in[14:12];
  assign w_rs1_idx = instruction_in[19:15];
  assign w_rs2_idx = instruction_in[24:20];
  assign w_funct7  = instruction_in[31:25];
  assign w_r_type  = (w_opcode == OPC_R);

  register_file_8bit #(.XLEN(XLEN)) u_rf (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_we      (wb_we),
    .i_waddr   (wb_rd),
    .i_wdata   (wb_data),
    .i_raddr1  (w_rs1_idx),
    .i_raddr2  (w_rs2_idx),
    .o_rdata1  (w_rf_rd1),
    .o_rdata2  (w_rf_rd2)
  );

  // ALU op from funct3/funct7; funct7 only qualifies shifts for I-ALU
  always_comb begin
    w_alu_ok = 1'b1;
    w_alu_op = ALU_ADD;
    case (w_funct3)
      F3_ADD_SUB: begin
        if (w_r_type && (w_funct7 == F7_ALT))       w_alu_op = ALU_SUB;
        else if (w_r_type && (w_funct7 != F7_BASE)) w_alu_ok = 1'b0;
      end
      F3_SLL: begin
        w_alu_op = ALU_SLL;
        w_alu_ok = (w_funct7 == F7_BASE);
      end
      F3_SLT: begin
        w_alu_op = ALU_SLT;
        w_alu_ok = !w_r_type || (w_funct7 == F7_BASE);
      end
      F3_XOR: begin
        w_alu_op = ALU_XOR;
        w_alu_ok = !w_r_type || (w_funct7 == F7_BASE);
      end
      F3_OR: begin
        w_alu_op = ALU_OR;
        w_alu_ok = !w_r_type || (w_funct7 == F7_BASE);
      end
      F3_AND: begin
        w_alu_op = ALU_AND;
        w_alu_ok = !w_r_type || (w_funct7 == F7_BASE);
      end
      F3_SRL_SRA: begin
        if (w_funct7 == F7_ALT)       w_alu_op = ALU_SRA;
        else if (w_funct7 == F7_BASE) w_alu_op = ALU_SRL;
        else                          w_alu_ok = 1'b0;
      end
      default: w_alu_ok = 1'b0;
    endcase
  end

  // Main decode: control, immediate and source-register usage; unknown encodings stay all-zero
  always_comb begin
    w_ctrl     = '0;
    w_imm      = '0;
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    case (w_opcode)
      OPC_R: if (w_alu_ok) begin
        w_ctrl.alu_op    = w_alu_op;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.valid     = 1'b1;
        w_rs1_used       = 1'b1;
        w_rs2_used       = 1'b1;
      end
      OPC_IALU: if (w_alu_ok) begin
        w_ctrl.alu_op    = w_alu_op;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.valid     = 1'b1;
        w_rs1_used       = 1'b1;
        w_imm            = XLEN'(instruction_in[27:20]);
      end
      OPC_LOAD: begin
        w_ctrl.alu_op     = ALU_ADD;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.valid      = 1'b1;
        w_rs1_used        = 1'b1;
        w_imm             = XLEN'(instruction_in[27:20]);
      end
      OPC_STORE: begin
        w_ctrl.alu_op    = ALU_ADD;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_ctrl.valid     = 1'b1;
        w_rs1_used       = 1'b1;
        w_rs2_used       = 1'b1;
        w_imm            = XLEN'({instruction_in[27:25], instruction_in[11:7]});
      end
      OPC_BRANCH: if ((w_funct3 == F3_BEQ) || (w_funct3 == F3_BNE)) begin
        w_ctrl.alu_op    = ALU_SUB;
        w_ctrl.branch    = 1'b1;
        w_ctrl.branch_ne = (w_funct3 == F3_BNE);
        w_ctrl.valid     = 1'b1;
        w_rs1_used       = 1'b1;
        w_rs2_used       = 1'b1;
        // B-imm[9:2]: word offset of the byte displacement
        w_imm            = XLEN'({instruction_in[29:25], instruction_in[11:9]});
      end
      default: ;
    endcase
  end

  // Load-use hazard against the load now in EX; flush and reset both override it
  assign w_hazard = ex_mem_read && (ex_rd != '0) &&
                    ((w_rs1_used && (ex_rd == w_rs1_idx)) || (w_rs2_used && (ex_rd == w_rs2_idx)));
  assign stall    = reset && !flush && w_hazard;
  assign w_bubble = flush || w_hazard || !w_ctrl.valid;

  // ID/EX pipeline register; bubbles clear the whole bundle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ctrl     <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else if (w_bubble) begin
      r_ctrl     <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else begin
      r_ctrl     <= w_ctrl;
      r_pc       <= PC_in;
      r_rs1_data <= w_rf_rd1;
      r_rs2_data <= w_rs2_used ? w_rf_rd2 : '0;
      r_imm      <= w_imm;
      r_rs1      <= w_rs1_idx;
      r_rs2      <= w_rs2_used ? w_rs2_idx : '0;
      r_rd       <= w_ctrl.reg_write ? w_rd_idx : '0;
    end
  end

  assign PC_out     = r_pc;
  assign rs1_data   = r_rs1_data;
  assign rs2_data   = r_rs2_data;
  assign imm        = r_imm;
  assign rs1        = r_rs1;
  assign rs2        = r_rs2;
  assign rd         = r_rd;
  assign alu_op     = r_ctrl.alu_op;
  assign alu_src    = r_ctrl.alu_src;
  assign mem_read   = r_ctrl.mem_read;
  assign mem_write  = r_ctrl.mem_write;
  assign reg_write  = r_ctrl.reg_write;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign branch     = r_ctrl.branch;
  assign branch_ne  = r_ctrl.branch_ne;
  assign valid      = r_ctrl.valid;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: vector table, directed corner sequences and random stimulus against a reference decoder.
module tb_id_stage;

`ifdef ID_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  PC_in = '0;
  logic [31:0] instruction_in = '0;
  logic        flush = 1'b0, wb_we = 1'b0, ex_mem_read = 1'b0;
  logic [4:0]  wb_rd = '0, ex_rd = '0;
  logic [7:0]  wb_data = '0;
  logic        stall;
  logic [9:0]  PC_out;
  logic [7:0]  rs1_data, rs2_data, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_op;
  logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, branch_ne, valid;

  always #5 clock = ~clock;

  id_stage dut (
    .clock(clock), .reset(reset), .PC_in(PC_in), .instruction_in(instruction_in),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .stall(stall), .PC_out(PC_out),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
    .alu_op(alu_op), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .branch(branch), .branch_ne(branch_ne),
    .valid(valid)
  );

  typedef struct packed {
    logic [9:0] pc;
    logic [7:0] rs1_data, rs2_data, imm;
    logic [4:0] rs1, rs2, rd;
    logic [3:0] alu_op;
    logic [7:0] ctl; // {alu_src,mem_read,mem_write,reg_write,mem_to_reg,branch,branch_ne,valid}
  } exp_t;

  typedef struct packed {
    logic [31:0] inst;
    logic        fl, mr;
    logic [4:0]  er;
    logic        st;
    logic [7:0]  ctl;
    logic [3:0]  alu;
    logic [7:0]  imm;
    logic [4:0]  rd;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] m_rf [32];

  task automatic chk(input string t, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", t, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d, input logic [6:0] op);
    return {im, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] s2, input logic [4:0] s1);
    return {im[11:5], s2, s1, 3'd2, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int off, input logic [4:0] s2, input logic [4:0] s1,
                                        input logic [2:0] f3);
    logic [12:0] o;
    o = 13'(off);
    return {o[12], o[10:5], s2, s1, f3, o[4:1], o[11], 7'h63};
  endfunction

  function automatic logic [7:0] rf_read(input logic [4:0] r, input logic we, input logic [4:0] wrd,
                                         input logic [7:0] wd);
    if (r == 5'd0) return 8'h00;
    if (BYP && we && (wrd == r)) return wd;
    return m_rf[r];
  endfunction

  // Reference decoder: what ID/EX should hold for this instruction if it is not squashed
  function automatic exp_t ref_decode(input logic [31:0] in, input logic [9:0] pc, input logic we,
                                      input logic [4:0] wrd, input logic [7:0] wd);
    exp_t e;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [11:0] i12, s12;
    logic signed [12:0] b13;
    int alu, off;
    bit src, mr, mw, rw, m2r, br, bne, use2;
    logic [7:0] im;
    e = '0;
    f7 = in[31:25]; f3 = in[14:12];
    i12 = in[31:20]; s12 = {in[31:25], in[11:7]};
    b13 = {in[31], in[7], in[30:25], in[11:8], 1'b0};
    alu = -1; src = 0; mr = 0; mw = 0; rw = 0; m2r = 0; br = 0; bne = 0; use2 = 0; im = 8'h00;
    case (in[6:0])
      7'h33: begin
        case ({f7, f3})
          {7'h00, 3'd0}: alu = 0;  {7'h20, 3'd0}: alu = 1;  {7'h00, 3'd7}: alu = 2;
          {7'h00, 3'd6}: alu = 3;  {7'h00, 3'd4}: alu = 4;  {7'h00, 3'd1}: alu = 5;
          {7'h00, 3'd5}: alu = 6;  {7'h20, 3'd5}: alu = 7;  {7'h00, 3'd2}: alu = 8;
          default: alu = -1;
        endcase
        rw = 1; use2 = 1;
      end
      7'h13: begin
        case (f3)
          3'd0: alu = 0;  3'd7: alu = 2;  3'd6: alu = 3;  3'd4: alu = 4;  3'd2: alu = 8;
          3'd1: alu = (f7 == 7'h00) ? 5 : -1;
          3'd5: alu = (f7 == 7'h00) ? 6 : ((f7 == 7'h20) ? 7 : -1);
          default: alu = -1;
        endcase
        src = 1; rw = 1; im = i12[7:0];
      end
      7'h03: begin alu = 0; src = 1; mr = 1; m2r = 1; rw = 1; im = i12[7:0]; end
      7'h23: begin alu = 0; src = 1; mw = 1; use2 = 1; im = s12[7:0]; end
      7'h63: begin
        if (f3 == 3'd0 || f3 == 3'd1) alu = 1;
        br = 1; bne = (f3 == 3'd1); use2 = 1;
        off = int'(b13);
        im = 8'(off >>> 2);
      end
      default: alu = -1;
    endcase
    if (alu < 0) return '0;
    e.pc = pc;
    e.alu_op = 4'(alu);
    e.ctl = {src, mr, mw, rw, m2r, br, bne, 1'b1};
    e.imm = im;
    e.rs1 = in[19:15];
    e.rs1_data = rf_read(in[19:15], we, wrd, wd);
    if (use2) begin
      e.rs2 = in[24:20];
      e.rs2_data = rf_read(in[24:20], we, wrd, wd);
    end
    if (rw) e.rd = in[11:7];
    return e;
  endfunction

  task automatic chk_out(input string t, input exp_t e);
    chk({t, " pc"}, 32'(PC_out), 32'(e.pc));
    chk({t, " rs1_data"}, 32'(rs1_data), 32'(e.rs1_data));
    chk({t, " rs2_data"}, 32'(rs2_data), 32'(e.rs2_data));
    chk({t, " imm"}, 32'(imm), 32'(e.imm));
    chk({t, " regidx"}, 32'({rs1, rs2, rd}), 32'({e.rs1, e.rs2, e.rd}));
    chk({t, " alu_op"}, 32'(alu_op), 32'(e.alu_op));
    chk({t, " ctl"}, 32'({alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, branch_ne, valid}),
        32'(e.ctl));
  endtask

  // One ID cycle: drive, check stall before the edge, update model regfile, check ID/EX after it
  task automatic cycle(input string t, input logic [31:0] in, input logic [9:0] pc, input logic fl,
                       input logic mr, input logic [4:0] er, input logic we, input logic [4:0] wrd,
                       input logic [7:0] wd, output logic st_got);
    exp_t e;
    logic st;
    instruction_in = in; PC_in = pc; flush = fl; ex_mem_read = mr; ex_rd = er;
    wb_we = we; wb_rd = wrd; wb_data = wd;
    #1;
    e = ref_decode(in, pc, we, wrd, wd);
    st = !fl && mr && (er != 5'd0) && ((er == e.rs1) || (er == e.rs2));
    st_got = stall;
    chk({t, " stall"}, 32'(stall), 32'(st));
    if (fl || st) e = '0;
    @(posedge clock);
    if (we && (wrd != 5'd0)) m_rf[wrd] = wd;
    #1;
    chk_out(t, e);
  endtask

  vec_t vt [20];

  initial begin
    logic st;
    logic [31:0] ri;
    logic [4:0] ra, rb, rc;
    for (int i = 0; i < 32; i++) m_rf[i] = 8'h00;

    vt[0]  = '{enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd5), 1'b0, 1'b0, 5'd0, 1'b0, 8'h11, 4'd0, 8'h00, 5'd5};
    vt[1]  = '{enc_r(7'h20, 5'd3, 5'd2, 3'd0, 5'd1), 1'b0, 1'b0, 5'd0, 1'b0, 8'h11, 4'd1, 8'h00, 5'd1};
    vt[2]  = '{enc_r(7'h20, 5'd1, 5'd2, 3'd5, 5'd2), 1'b0, 1'b0, 5'd0, 1'b0, 8'h11, 4'd7, 8'h00, 5'd2};
    vt[3]  = '{enc_r(7'h00, 5'd4, 5'd3, 3'd2, 5'd9), 1'b0, 1'b0, 5'd0, 1'b0, 8'h11, 4'd8, 8'h00, 5'd9};
    vt[4]  = '{enc_r(7'h00, 5'd4, 5'd3, 3'd3, 5'd9), 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 4'd0, 8'h00, 5'd0};
    vt[5]  = '{enc_i(12'd7, 5'd4, 3'd0, 5'd6, 7'h13), 1'b0, 1'b0, 5'd0, 1'b0, 8'h91, 4'd0, 8'h07, 5'd6};
    vt[6]  = '{enc_i(12'hFFF, 5'd1, 3'd4, 5'd1, 7'h13), 1'b0, 1'b0, 5'd0, 1'b0, 8'h91, 4'd4, 8'hFF, 5'd1};
    vt[7]  = '{enc_i(12'h405, 5'd2, 3'd5, 5'd3, 7'h13), 1'b0, 1'b0, 5'd0, 1'b0, 8'h91, 4'd7, 8'h05, 5'd3};
    vt[8]  = '{enc_i(12'd5, 5'd2, 3'd2, 5'd9, 7'h03), 1'b0, 1'b0, 5'd0, 1'b0, 8'hD9, 4'd0, 8'h05, 5'd9};
    vt[9]  = '{enc_s(12'h025, 5'd3, 5'd2), 1'b0, 1'b0, 5'd0, 1'b0, 8'hA1, 4'd0, 8'h25, 5'd0};
    vt[10] = '{enc_b(-8, 5'd2, 5'd1, 3'd1), 1'b0, 1'b0, 5'd0, 1'b0, 8'h07, 4'd1, 8'hFE, 5'd0};
    vt[11] = '{enc_b(12, 5'd2, 5'd1, 3'd0), 1'b0, 1'b0, 5'd0, 1'b0, 8'h05, 4'd1, 8'h03, 5'd0};
    vt[12] = '{32'h000012B7, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 4'd0, 8'h00, 5'd0};
    vt[13] = '{enc_i(12'd7, 5'd4, 3'd0, 5'd6, 7'h13), 1'b0, 1'b1, 5'd4, 1'b1, 8'h00, 4'd0, 8'h00, 5'd0};
    vt[14] = '{enc_b(8, 5'd3, 5'd3, 3'd0), 1'b1, 1'b1, 5'd3, 1'b0, 8'h00, 4'd0, 8'h00, 5'd0};
    vt[15] = '{enc_i(12'd7, 5'd4, 3'd0, 5'd6, 7'h13), 1'b0, 1'b1, 5'd6, 1'b0, 8'h91, 4'd0, 8'h07, 5'd6};
    vt[16] = '{enc_i(12'd4, 5'd2, 3'd0, 5'd1, 7'h13), 1'b0, 1'b1, 5'd4, 1'b0, 8'h91, 4'd0, 8'h04, 5'd1};
    vt[17] = '{enc_s(12'h025, 5'd3, 5'd2), 1'b0, 1'b1, 5'd3, 1'b1, 8'h00, 4'd0, 8'h00, 5'd0};
    vt[18] = '{enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'h13), 1'b0, 1'b1, 5'd0, 1'b0, 8'h91, 4'd0, 8'h01, 5'd1};
    vt[19] = '{enc_b(12, 5'd2, 5'd1, 3'd4), 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 4'd0, 8'h00, 5'd0};

    // Reset state
    #2;
    chk("reset stall", 32'(stall), 32'd0);
    chk_out("reset", '0);
    #10 reset = 1'b1;

    // Vector table
    for (int i = 0; i < 20; i++) begin
      cycle($sformatf("vec%0d", i), vt[i].inst, 10'(i + 1), vt[i].fl, vt[i].mr, vt[i].er,
            1'b0, 5'd0, 8'h00, st);
      chk($sformatf("vec%0d tbl_stall", i), 32'(st), 32'(vt[i].st));
      chk($sformatf("vec%0d tbl_ctl", i),
          32'({alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, branch_ne, valid}), 32'(vt[i].ctl));
      chk($sformatf("vec%0d tbl_alu", i), 32'(alu_op), 32'(vt[i].alu));
      chk($sformatf("vec%0d tbl_imm", i), 32'(imm), 32'(vt[i].imm));
      chk($sformatf("vec%0d tbl_rd", i), 32'(rd), 32'(vt[i].rd));
    end

    // Writeback then dependent ADD x5,x3,x3
    cycle("wb_x3", 32'h0, 10'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 8'h5A, st);
    cycle("add_x3", enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd5), 10'h40, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h0, st);
    chk("add_x3 data", 32'({rs1_data, rs2_data}), 32'h5A5A);

    // Load-use: stall, then re-decode once the load has left EX
    cycle("lu_stall", enc_i(12'd7, 5'd4, 3'd0, 5'd6, 7'h13), 10'h41, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0, 8'h0, st);
    chk("lu_stall seen", 32'({st, valid}), 32'b10);
    cycle("lu_go", enc_i(12'd7, 5'd4, 3'd0, 5'd6, 7'h13), 10'h41, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h0, st);
    chk("lu_go imm/valid", 32'({imm, valid}), {23'd0, 8'h07, 1'b1});

    // Flush with write: write still lands
    cycle("fl_wb", enc_b(8, 5'd7, 5'd7, 3'd0), 10'h42, 1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 8'h22, st);
    // Same-cycle write and read of x7
    cycle("byp", enc_r(7'h00, 5'd7, 5'd7, 3'd0, 5'd8), 10'h43, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 8'h11, st);
    chk("byp rs1_data", 32'(rs1_data), BYP ? 32'h11 : 32'h22);
    cycle("after_byp", enc_r(7'h00, 5'd7, 5'd7, 3'd0, 5'd8), 10'h44, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h0, st);
    chk("after_byp rs1_data", 32'(rs1_data), 32'h11);

    // Reset asserted mid-stall with live outputs
    instruction_in = enc_r(7'h00, 5'd7, 5'd7, 3'd0, 5'd8); ex_mem_read = 1'b1; ex_rd = 5'd7;
    #1;
    chk("pre_rst stall", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst stall", 32'(stall), 32'd0);
    chk_out("mid_rst", '0);
    for (int i = 0; i < 32; i++) m_rf[i] = 8'h00;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 1; i < 32; i++) begin
      cycle("clr", enc_r(7'h00, 5'((i % 31) + 1), 5'(i), 3'd6, 5'd1), 10'(i), 1'b0, 1'b0, 5'd0,
            1'b0, 5'd0, 8'h0, st);
      chk($sformatf("clr x%0d", i), 32'({rs1_data, rs2_data}), 32'd0);
    end

    // Random traffic against the reference decoder
    for (int n = 0; n < 400; n++) begin
      ra = 5'($urandom_range(0, 7)); rb = 5'($urandom_range(0, 7)); rc = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 6))
        0: ri = enc_r(($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00, rb, ra, 3'($urandom), rc);
        1: ri = enc_i(12'($urandom), ra, 3'($urandom), rc, 7'h13);
        2: ri = enc_i(12'($urandom), ra, 3'($urandom), rc, 7'h03);
        3: ri = enc_s(12'($urandom), rb, ra);
        4: ri = enc_b(int'($urandom_range(0, 1023)) * 2 - 1024, rb, ra, 3'($urandom_range(0, 2)));
        5: ri = enc_r(7'h00, rb, ra, 3'($urandom), rc);
        default: ri = $urandom;
      endcase
      cycle("rnd", ri, 10'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 8'($urandom), st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
